// File: rtl/ram_arbiter.sv
// Shares the 256x16 data RAM between the CPU memory stage (fixed priority per port)
// and a host/debug port. Define RAM_ARB_STALL_EN to bound host waiting by stalling the CPU.
module ram_arbiter #(
  parameter int AWIDTH     = 8,
  parameter int DWIDTH     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_raddr,
  input  logic [AWIDTH-1:0] cpu_waddr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [AWIDTH-1:0] h_addr,
  input  logic [DWIDTH-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DWIDTH-1:0] h_rdata,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              port_free_s;
  logic              gnt_s;
  logic              force_s;
  logic              starved_s;
  logic              h_rd_gnt_s;
  logic              h_wr_gnt_s;
  logic              rvalid_s;
  logic [DWIDTH-1:0] h_rdata_r;

  // The host needs the read port for reads and the write port for writes.
  always_comb begin
    port_free_s = h_we ? ~cpu_wr : ~cpu_rd;
  end

`ifdef RAM_ARB_STALL_EN
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_next_s;

  // Starvation detect: counter has reached its saturation value.
  always_comb begin
    starved_s = (wait_cnt_r == CW'(STARVE_MAX));
  end

  // Count only WAIT cycles without a grant; anything else clears it.
  always_comb begin
    wait_cnt_next_s = {CW{1'b0}};
    if ((state_r == ST_WAIT) && h_req && !gnt_s) begin
      if (starved_s) begin
        wait_cnt_next_s = wait_cnt_r;
      end else begin
        wait_cnt_next_s = wait_cnt_r + CW'(1);
      end
    end else begin
      wait_cnt_next_s = {CW{1'b0}};
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CW{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_next_s;
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;

  // Pure fixed priority: the host is never forced in.
  always_comb begin
    starved_s = 1'b0;
  end
`endif

  // Next-state and grant decode.
  always_comb begin
    state_next_s = state_r;
    gnt_s        = 1'b0;
    force_s      = 1'b0;
    if (rst) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!h_req) begin
            state_next_s = ST_IDLE;
          end else if (port_free_s) begin
            gnt_s        = 1'b1;
            state_next_s = h_we ? ST_IDLE : ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A dropped request is a host protocol violation; abandon quietly.
          if (!h_req) begin
            state_next_s = ST_IDLE;
          end else if (port_free_s) begin
            gnt_s        = 1'b1;
            state_next_s = h_we ? ST_IDLE : ST_RESP;
          end else if (starved_s) begin
            gnt_s        = 1'b1;
            force_s      = 1'b1;
            state_next_s = h_we ? ST_IDLE : ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
          end
        end
        ST_RESP: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Split the grant per port.
  always_comb begin
    h_rd_gnt_s = gnt_s & ~h_we;
    h_wr_gnt_s = gnt_s & h_we;
  end

  // RAM port steering: CPU passes straight through unless the host holds the port.
  always_comb begin
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_raddr = cpu_raddr;
    ram_waddr = cpu_waddr;
    ram_wdata = cpu_wdata;
    if (rst) begin
      ram_rd = 1'b0;
      ram_wr = 1'b0;
    end else begin
      if (h_rd_gnt_s) begin
        ram_rd    = 1'b1;
        ram_raddr = h_addr;
      end else begin
        ram_rd    = cpu_rd;
        ram_raddr = cpu_raddr;
      end
      if (h_wr_gnt_s) begin
        ram_wr    = 1'b1;
        ram_waddr = h_addr;
        ram_wdata = h_wdata;
      end else begin
        ram_wr    = cpu_wr;
        ram_waddr = cpu_waddr;
        ram_wdata = cpu_wdata;
      end
    end
  end

  // RESP is the cycle the RAM returns host data; a reset here abandons the read.
  always_comb begin
    rvalid_s = (state_r == ST_RESP) && !rst;
  end

  // Hold the last host read result for inspection after the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_rdata_r <= {DWIDTH{1'b0}};
    end else if (rvalid_s) begin
      h_rdata_r <= ram_rdata;
    end else begin
      h_rdata_r <= h_rdata_r;
    end
  end

  // Output drive; read data bypasses the holding register in the valid cycle.
  always_comb begin
    h_gnt     = gnt_s;
    cpu_stall = force_s;
    h_rvalid  = rvalid_s;
    h_rdata   = rvalid_s ? ram_rdata : h_rdata_r;
    cpu_rdata = ram_rdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a 1-cycle-latency RAM model.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_raddr, cpu_waddr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        h_req, h_we;
  logic [7:0]  h_addr;
  logic [15:0] h_wdata;
  logic        h_gnt, h_rvalid;
  logic [15:0] h_rdata;
  logic        ram_rd, ram_wr;
  logic [7:0]  ram_raddr, ram_waddr;
  logic [15:0] ram_wdata, ram_rdata;

  logic [15:0] mem [256];
  int n_cmp;
  int n_err;

  ram_arbiter #(.AWIDTH(8), .DWIDTH(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_waddr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; h_req = 1'b1; h_we = 1'b0;
    tick(); tick(); #1;
    n_cmp++; if (ram_rd !== 1'b0) begin n_err++; $display("FAIL reset_ram_rd: got %b want 0", ram_rd); end
    n_cmp++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
    n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL reset_h_gnt: got %b want 0", h_gnt); end
    n_cmp++; if (h_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_h_rvalid: got %b want 0", h_rvalid); end
    n_cmp++; if (h_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_h_rdata: got %h want 0000", h_rdata); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall); end
    tick();
    rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; h_req = 1'b0;
  endtask

  task automatic test_idle_host();
    tick(); h_req = 1'b1; h_we = 1'b1; h_addr = 8'h10; h_wdata = 16'hBEEF; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL idle_wr_gnt: got %b want 1", h_gnt); end
    n_cmp++; if ({ram_wr, ram_waddr, ram_wdata} !== {1'b1, 8'h10, 16'hBEEF})
      begin n_err++; $display("FAIL idle_wr_port: got %b/%h/%h want 1/10/beef", ram_wr, ram_waddr, ram_wdata); end
    tick(); h_we = 1'b0; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL idle_rd_gnt: got %b want 1", h_gnt); end
    n_cmp++; if ({ram_rd, ram_raddr} !== {1'b1, 8'h10})
      begin n_err++; $display("FAIL idle_rd_port: got %b/%h want 1/10", ram_rd, ram_raddr); end
    tick(); h_req = 1'b0; #1;
    n_cmp++; if (h_rvalid !== 1'b1) begin n_err++; $display("FAIL idle_rvalid: got %b want 1", h_rvalid); end
    n_cmp++; if (h_rdata !== 16'hBEEF) begin n_err++; $display("FAIL idle_rdata: got %h want beef", h_rdata); end
    n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL idle_resp_nognt: got %b want 0", h_gnt); end
    tick(); #1;
    n_cmp++; if (h_rvalid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid_pulse: got %b want 0", h_rvalid); end
    n_cmp++; if (h_rdata !== 16'hBEEF) begin n_err++; $display("FAIL idle_rdata_hold: got %h want beef", h_rdata); end
  endtask

  task automatic test_back_to_back();
    tick(); h_req = 1'b1; h_we = 1'b1; h_addr = 8'h20; h_wdata = 16'hAAAA; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt0: got %b want 1", h_gnt); end
    tick(); h_addr = 8'h21; h_wdata = 16'h5555; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt1: got %b want 1", h_gnt); end
    tick(); h_addr = 8'h30; h_wdata = 16'h0F0F; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt2: got %b want 1", h_gnt); end
    tick(); h_req = 1'b0;
  endtask

  task automatic test_cpu_read_priority();
    tick(); cpu_rd = 1'b1; cpu_raddr = 8'h20; h_req = 1'b1; h_we = 1'b0; h_addr = 8'h21; #1;
    n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL prio_gnt_c0: got %b want 0", h_gnt); end
    for (int i = 1; i < 3; i++) begin
      tick(); #1;
      n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL prio_gnt_c%0d: got %b want 0", i, h_gnt); end
      n_cmp++; if (cpu_rdata !== 16'hAAAA) begin n_err++; $display("FAIL prio_cpu_rdata_c%0d: got %h want aaaa", i, cpu_rdata); end
    end
    tick(); cpu_rd = 1'b0; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL prio_gnt_after: got %b want 1", h_gnt); end
    n_cmp++; if (ram_raddr !== 8'h21) begin n_err++; $display("FAIL prio_raddr: got %h want 21", ram_raddr); end
    n_cmp++; if (cpu_rdata !== 16'hAAAA) begin n_err++; $display("FAIL prio_cpu_rdata_c3: got %h want aaaa", cpu_rdata); end
    tick(); h_req = 1'b0; #1;
    n_cmp++; if (h_rvalid !== 1'b1) begin n_err++; $display("FAIL prio_rvalid: got %b want 1", h_rvalid); end
    n_cmp++; if (h_rdata !== 16'h5555) begin n_err++; $display("FAIL prio_rdata: got %h want 5555", h_rdata); end
  endtask

  task automatic test_host_write_cpu_read();
    tick(); cpu_rd = 1'b1; cpu_raddr = 8'h30; h_req = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = 16'h1234; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL hwcr_gnt: got %b want 1", h_gnt); end
    n_cmp++; if ({ram_rd, ram_raddr} !== {1'b1, 8'h30})
      begin n_err++; $display("FAIL hwcr_cpu_pass: got %b/%h want 1/30", ram_rd, ram_raddr); end
    tick(); h_req = 1'b0; #1;
    n_cmp++; if (cpu_rdata !== 16'h0F0F) begin n_err++; $display("FAIL hwcr_old_data: got %h want 0f0f", cpu_rdata); end
    tick(); #1;
    n_cmp++; if (cpu_rdata !== 16'h1234) begin n_err++; $display("FAIL hwcr_new_data: got %h want 1234", cpu_rdata); end
    tick(); cpu_rd = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    tick(); h_req = 1'b1; h_we = 1'b0; h_addr = 8'h30; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL rresp_gnt: got %b want 1", h_gnt); end
    tick(); h_req = 1'b0; rst = 1'b1; #1;
    n_cmp++; if (h_rvalid !== 1'b0) begin n_err++; $display("FAIL rresp_rvalid_rst: got %b want 0", h_rvalid); end
    tick(); rst = 1'b0; #1;
    n_cmp++; if (h_rvalid !== 1'b0) begin n_err++; $display("FAIL rresp_rvalid_after: got %b want 0", h_rvalid); end
    n_cmp++; if (h_rdata !== 16'h0000) begin n_err++; $display("FAIL rresp_rdata: got %h want 0000", h_rdata); end
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10; #1;
    n_cmp++; if (h_gnt !== 1'b1) begin n_err++; $display("FAIL rresp_idle_gnt: got %b want 1", h_gnt); end
    tick(); h_req = 1'b0; #1;
    n_cmp++; if (h_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rresp_reread: got %h want beef", h_rdata); end
  endtask

`ifdef RAM_ARB_STALL_EN
  task automatic test_starve();
    tick(); cpu_wr = 1'b1; cpu_waddr = 8'h40; cpu_wdata = 16'h1111;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h41; h_wdata = 16'h2222; #1;
    n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL starve_gnt_c0: got %b want 0", h_gnt); end
    for (int i = 1; i < 5; i++) begin
      tick(); #1;
      n_cmp++; if ({h_gnt, cpu_stall, ram_waddr} !== {1'b0, 1'b0, 8'h40})
        begin n_err++; $display("FAIL starve_wait_c%0d: got %b/%b/%h want 0/0/40", i, h_gnt, cpu_stall, ram_waddr); end
    end
    tick(); #1;
    n_cmp++; if ({h_gnt, cpu_stall} !== 2'b11) begin n_err++; $display("FAIL starve_force: got %b/%b want 1/1", h_gnt, cpu_stall); end
    n_cmp++; if ({ram_wr, ram_waddr, ram_wdata} !== {1'b1, 8'h41, 16'h2222})
      begin n_err++; $display("FAIL starve_port: got %b/%h/%h want 1/41/2222", ram_wr, ram_waddr, ram_wdata); end
    tick(); h_req = 1'b0; #1;
    n_cmp++; if ({h_gnt, cpu_stall, ram_waddr} !== {1'b0, 1'b0, 8'h40})
      begin n_err++; $display("FAIL starve_release: got %b/%b/%h want 0/0/40", h_gnt, cpu_stall, ram_waddr); end
    tick(); cpu_wr = 1'b0; h_req = 1'b1; h_we = 1'b0; h_addr = 8'h41; #1;
    tick(); h_req = 1'b0; #1;
    n_cmp++; if (h_rdata !== 16'h2222) begin n_err++; $display("FAIL starve_readback: got %h want 2222", h_rdata); end
  endtask
`else
  task automatic test_no_stall();
    tick(); cpu_wr = 1'b1; cpu_waddr = 8'h40; cpu_wdata = 16'h1111;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h41; h_wdata = 16'h2222; #1;
    for (int i = 0; i < 50; i++) begin
      n_cmp++; if ({h_gnt, cpu_stall} !== 2'b00)
        begin n_err++; $display("FAIL nostall_c%0d: got gnt=%b stall=%b want 0/0", i, h_gnt, cpu_stall); end
      tick(); #1;
    end
    h_req = 1'b0; cpu_wr = 1'b0; #1;
    n_cmp++; if (h_gnt !== 1'b0) begin n_err++; $display("FAIL nostall_drop: got %b want 0", h_gnt); end
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_raddr = 8'h00; cpu_waddr = 8'h00;
    cpu_wdata = 16'h0000; h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 16'h0000;
    test_reset();
    test_idle_host();
    test_back_to_back();
    test_cpu_read_priority();
    test_host_write_cpu_read();
    test_reset_in_resp();
`ifdef RAM_ARB_STALL_EN
    test_starve();
`else
    test_no_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the CPU's 256 x 16 data RAM between the CPU memory stage and an external host/debug port. The CPU keeps fixed priority on each RAM port. The host gets granted accesses through a request/grant handshake whenever the port it needs is idle. The block sits between the CPU pipeline's RAM control signals and the `ram` instance; the host side drives the program-load and inspection paths used by the testbench and the debug interface.

## Interface
- AWIDTH, 8, RAM address width
- DWIDTH, 16, RAM data width
- STARVE_MAX, 4, host wait cycles before forced grant (only used with RAM_ARB_STALL_EN)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_rd  in  1  CPU read request (MEM stage)
- cpu_wr  in  1  CPU write request
- cpu_raddr  in  AWIDTH  CPU read address
- cpu_waddr  in  AWIDTH  CPU write address
- cpu_wdata  in  DWIDTH  CPU write data
- cpu_rdata  out  DWIDTH  CPU read data, = ram_rdata
- cpu_stall  out  1  CPU must hold its access this cycle (0 when RAM_ARB_STALL_EN is undefined)
- h_req  in  1  host request, held until h_gnt
- h_we  in  1  host: 1 = write, 0 = read
- h_addr  in  AWIDTH  host address
- h_wdata  in  DWIDTH  host write data
- h_gnt  out  1  one-cycle grant pulse; the access is issued to RAM in this cycle
- h_rvalid  out  1  one-cycle pulse; h_rdata is valid
- h_rdata  out  DWIDTH  registered host read data, held until the next host read
- ram_rd, ram_wr  out  1  to RAM
- ram_raddr, ram_waddr  out  AWIDTH  to RAM
- ram_wdata  out  DWIDTH  to RAM
- ram_rdata  in  DWIDTH  from RAM; 1-cycle read latency

## Operation
- Read and write ports are arbitrated independently:
  - host read wins the read port only if cpu_rd=0;
  - host write wins the write port only if cpu_wr=0.
- CPU accesses are passed through combinationally to the RAM ports (ram_rd=cpu_rd, addresses, data) unless a stall is in effect.
- FSM states:
  - IDLE: on h_req, if the required port is free, assert h_gnt and drive the RAM port from the host. Next state is RESP for a read, IDLE for a write. If the port is busy, go to WAIT.
  - WAIT: same grant rule, evaluated every cycle. wait_cnt increments each cycle without a grant, saturating at STARVE_MAX.
  - RESP: capture ram_rdata into h_rdata and pulse h_rvalid. No grant is given in this state. Next state is always IDLE.
- wait_cnt clears on any grant.
- h_req dropping in WAIT returns the FSM to IDLE with no access; this is a protocol violation and is tolerated.
- Host write and CPU read to the same address in the same cycle: the CPU reads the old data. This is the RAM's behaviour and is not corrected.
- Host throughput: one write per cycle, one read per two cycles.

## Timing
- Reset: state IDLE, wait_cnt=0, h_gnt=0, h_rvalid=0, h_rdata=0, cpu_stall=0, ram_rd=ram_wr=0.
- Reset asserted in RESP: the pending read is abandoned and no h_rvalid is produced.
- h_gnt is combinational from state, h_req, h_we, cpu_rd and cpu_wr. The RAM strobe goes out in the same cycle.
- Host read latency: h_gnt in cycle N, h_rvalid/h_rdata in cycle N+1. Minimum request-to-data latency is 1 cycle.
- cpu_rdata is ram_rdata unregistered. The CPU sees its data at N+1, unchanged from direct RAM attachment.

## Configuration
- RAM_ARB_STALL_EN defined:
  - in WAIT with wait_cnt==STARVE_MAX, the host is force-granted: h_gnt=1, and cpu_stall=1 for that single cycle;
  - the CPU's conflicting access is suppressed and must be re-presented next cycle;
  - the bound is at most STARVE_MAX+1 cycles from request to grant.
- RAM_ARB_STALL_EN undefined:
  - pure fixed priority: cpu_stall is tied 0, wait_cnt is not implemented, and the host may starve indefinitely.

## Test plan
- Idle CPU: host writes 0xBEEF to 0x10, then reads 0x10. Expect h_gnt on the request cycle and h_rvalid one cycle after the read grant with h_rdata=0xBEEF.
- CPU reads 0x20 every cycle for 3 cycles while the host reads 0x21. Expect h_gnt only after cpu_rd drops, and cpu_rdata uncorrupted throughout.
- CPU reads continuously while the host writes 0x1234 to 0x30. Expect the host write granted immediately (write port free) and a later CPU read of 0x30 returning 0x1234.
- Reset asserted the cycle after a host read grant. Expect no h_rvalid, h_rdata=0, and the FSM in IDLE.
- With RAM_ARB_STALL_EN and STARVE_MAX=4: continuous cpu_wr while the host writes. Expect h_gnt and cpu_stall together in cycle 5 after the request, and the CPU write absent from RAM that cycle.
- Without RAM_ARB_STALL_EN, same stimulus for 50 cycles: expect cpu_stall=0 and h_gnt=0 throughout.
